// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - holding-register handshake bundle between uart_rx and its consumer
//
// Signals:
//   rd         consumer read strobe (consumer -> receiver)
//   data_out   last received byte
//   rx_valid   holding register full (level)
//   frame_err  one-cycle pulse on a stop-bit error
//   overrun    sticky: an unread byte was overwritten
//   busy       receiver FSM is not idle
// Modports: master = receiver side, slave = consumer side.
interface uart_rx_if;
    logic       rd;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        input  rd,
        output data_out, rx_valid, frame_err, overrun, busy
    );

    modport slave (
        output rd,
        input  data_out, rx_valid, frame_err, overrun, busy
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and one-deep holding register
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   rx_in    asynchronous serial line, idle high
//   bus      uart_rx_if.master: rd in; data_out, rx_valid, frame_err, overrun, busy out
// Parameter:
//   CLOCKS_PER_BAUD  clock cycles per bit (>= 4)
module uart_rx #(
    parameter logic [23:0] CLOCKS_PER_BAUD = 24'd2604
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_in,
    uart_rx_if.master  bus
);

    localparam logic [23:0] HALF = CLOCKS_PER_BAUD >> 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic        sync_1, rx_s, rx_q;
    logic [23:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [7:0]  shreg, sh_nxt;
    logic        byte_done, frame_bad;
    logic        fall;

    assign fall     = rx_q & ~rx_s;
    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != 24'd0) ? cnt - 24'd1 : cnt;
        bit_nxt   = bit_idx;
        sh_nxt    = shreg;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = cnt;
                if (fall) begin
                    cnt_nxt   = HALF - 24'd1;
                    state_nxt = START;
                end
            end
            START: begin
                if (cnt == 24'd0) begin
                    if (!rx_s) begin
                        cnt_nxt   = CLOCKS_PER_BAUD - 24'd1;
                        bit_nxt   = 3'd0;
                        state_nxt = DATA;
                    end else begin
                        // Line already back high at mid start bit: a glitch.
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt == 24'd0) begin
                    sh_nxt  = {rx_s, shreg[7:1]};
                    cnt_nxt = CLOCKS_PER_BAUD - 24'd1;
                    bit_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == 24'd0) begin
                    if (rx_s) begin
                        byte_done = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                // Hold off until the line returns high so a long break
                // yields a single frame_err.
                cnt_nxt = cnt;
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1        <= 1'b1;
            rx_s          <= 1'b1;
            rx_q          <= 1'b1;
            cnt           <= 24'd0;
            bit_idx       <= 3'd0;
            shreg         <= 8'h00;
            bus.data_out  <= 8'h00;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            sync_1        <= rx_in;
            rx_s          <= sync_1;
            rx_q          <= rx_s;
            cnt           <= cnt_nxt;
            bit_idx       <= bit_nxt;
            shreg         <= sh_nxt;
            bus.frame_err <= frame_bad;
            if (byte_done) begin
                bus.data_out <= shreg;
                bus.rx_valid <= 1'b1;
                // A read in the same cycle consumes the old byte, so the
                // overwrite is not an overrun.
                if (bus.rx_valid && !bus.rd) begin
                    bus.overrun <= 1'b1;
                end else if (bus.rx_valid && bus.rd) begin
                    bus.overrun <= 1'b0;
                end
            end else if (bus.rd && bus.rx_valid) begin
                bus.rx_valid <= 1'b0;
                bus.overrun  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-wide 8N1 UART receiver: the receive path that pairs with the existing `uart_tx` on the Nexys A7 tic-tac-toe serial link. Synchronizes the asynchronous `rx_in` pin, detects and validates the start bit, samples each bit at mid-bit, and presents the byte in a one-deep holding register with a valid/read handshake. Flags framing errors and overruns. Feeds the game-command decoder.

## Interface

Parameters:
- `CLOCKS_PER_BAUD`, 24'd2604, clock cycles per bit (25 MHz / 9600). Legal range is 4 or more. `HALF = CLOCKS_PER_BAUD >> 1`.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx_in`  in  1  serial line, idle high, asynchronous to `clk`.
- `rd`  in  1  consumer read strobe; clears `rx_valid` and `overrun`.
- `data_out`  out  8  last received byte; holds until replaced.
- `rx_valid`  out  1  holding register full; level signal.
- `frame_err`  out  1  one-cycle pulse when the stop bit samples 0.
- `overrun`  out  1  sticky flag: an unread byte was overwritten.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation

- Reset (async assert, sync release) sets: `data_out`=8'h00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0. The FSM goes to IDLE, the counter to 0, and both synchronizer flops and the edge-history flop to 1.
- Input conditioning:
  - 2-flop synchronizer produces `rx_s`.
  - `rx_q` is `rx_s` delayed by one cycle.
  - A falling edge is `rx_q & ~rx_s`.
- States: IDLE, START, DATA, STOP, BREAK.
- IDLE: on a falling edge, load the counter with `HALF-1` and go to START.
- START: when the counter reaches 0, sample `rx_s`.
  - If 0: reload `CLOCKS_PER_BAUD-1`, clear the bit index, go to DATA.
  - If 1: treat as a glitch and return to IDLE. No flags.
- DATA: on each counter zero, shift `rx_s` in LSB-first (bit 0 first) and reload the counter. After the 8th sample, go to STOP.
- STOP: on counter zero, sample `rx_s`.
  - If 1: write the shift register to `data_out`, set `rx_valid`, go to IDLE.
  - If 0: pulse `frame_err`, discard the byte (`data_out` and `rx_valid` unchanged), go to BREAK.
- BREAK: wait until `rx_s`=1, then go to IDLE. This means a held-low line produces exactly one `frame_err`.
- Holding-register handshake:
  - `rd` with `rx_valid`=1 clears `rx_valid` and `overrun` next cycle.
  - `rd` with `rx_valid`=0 has no effect.
- Byte completes while `rx_valid`=1 and `rd`=0: `data_out` is overwritten, `rx_valid` stays 1, `overrun` is set.
- Byte completes in the same cycle as `rd`: the new byte is loaded, `rx_valid` stays 1, `overrun` is cleared and not set.
- The counter is 24-bit, decrementing, and reloaded only at the points above. No wrap is possible.

## Timing

- Let E be the cycle in which the falling edge is detected. This is 2–3 cycles after the pin falls.
- Start sample at E+HALF.
- Data bit k (k=0..7) sampled at E+HALF+(k+1)·CLOCKS_PER_BAUD.
- Stop sample at S = E+HALF+9·CLOCKS_PER_BAUD.
- `rx_valid`, `data_out` and `frame_err` update at S+1.
- `busy` rises at E+1 and falls on the cycle the FSM re-enters IDLE.
- Back-to-back frames:
  - The FSM is in IDLE from S+1.
  - A start edge arriving half a bit after the stop-bit sample point is caught.
  - Tolerates ±4% baud mismatch.
- Reset mid-frame aborts immediately. The partial byte is lost and no flags are raised after release.

## Test plan

- Nominal: CLOCKS_PER_BAUD=16. Send 8'hA5 8N1 -> at S+1, `data_out`=8'hA5 and `rx_valid`=1. `rd` then clears `rx_valid` next cycle. `frame_err`=0.
- Glitch: `rx_in` low for 4 cycles (< HALF=8) -> FSM returns to IDLE, `rx_valid` stays 0, no `frame_err`.
- Framing error: send 8'h3C with stop bit 0, line held low for 40 bit-times, then high -> exactly one `frame_err` pulse, `rx_valid`=0. The next frame 8'h5A is received correctly.
- Overrun: send 8'h11 then 8'h22 with no `rd` -> `data_out`=8'h22, `overrun`=1. A `rd` clears both `rx_valid` and `overrun`.
- Simultaneous: assert `rd` exactly at the S+1 update of the second byte -> `rx_valid`=1, `overrun`=0, `data_out`=second byte.
- Reset mid-frame: deassert `reset_n` during bit 4 of 8'hFF -> all outputs at reset values. After release, a following 8'h81 is received intact.
